// File: rtl/list_walker_pkg.sv
// list_walker_pkg: shared state encodings, default widths and small helpers
// for the list walker and its wait counter.
package list_walker_pkg;

  // Word width of the memory unit; pointers and elements share it.
  localparam int unsigned MEMORY_DATA_WIDTH = 24;

  localparam int unsigned LW_DATA_WIDTH     = MEMORY_DATA_WIDTH;
  localparam int unsigned LW_COUNT_WIDTH    = 8;
  localparam int unsigned LW_MAX_STEPS      = 255;
  localparam int unsigned LW_TIMEOUT_CYCLES = 64;
  localparam int unsigned LW_NIL            = 0;

  // Walker FSM encodings.
  localparam int unsigned LW_STATE_W = 3;
  localparam logic [2:0] LW_IDLE     = 3'd0;
  localparam logic [2:0] LW_REQ_CAR  = 3'd1;
  localparam logic [2:0] LW_WAIT_CAR = 3'd2;
  localparam logic [2:0] LW_EMIT     = 3'd3;
  localparam logic [2:0] LW_REQ_CDR  = 3'd4;
  localparam logic [2:0] LW_WAIT_CDR = 3'd5;
  localparam logic [2:0] LW_DONE     = 3'd6;

  // One-hot-ish memory request strobes; car and cdr are never both set.
  typedef struct packed {
    logic car;
    logic cdr;
  } lw_mem_req_t;

  // True in the two states that wait on a memory response.
  function automatic logic lw_is_wait(input logic [2:0] s);
    return (s == LW_WAIT_CAR) || (s == LW_WAIT_CDR);
  endfunction

  // True in the two single-cycle request states.
  function automatic logic lw_is_req(input logic [2:0] s);
    return (s == LW_REQ_CAR) || (s == LW_REQ_CDR);
  endfunction

endpackage

// File: rtl/walker_timeout.sv
// walker_timeout: loadable down-counter bounding a single memory wait.
// load_i restarts the count; expired_o rises once en_i has been high for
// TIMEOUT_CYCLES consecutive cycles since the load.
module walker_timeout
  import list_walker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LW_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  // The flag is judged in the last waiting cycle, so count to TIMEOUT_CYCLES-1.
  localparam int unsigned LOAD_VAL = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned CNT_W    = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Next count: reload on entry to a wait, otherwise decrement toward zero.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = expired_q;
    if (load_i) begin
      cnt_d     = CNT_W'(LOAD_VAL);
      expired_d = (LOAD_VAL == 0);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d     = cnt_q - CNT_W'(1);
      expired_d = (cnt_q == CNT_W'(1));
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/list_walker.sv
// list_walker: walks a cons-cell list from head_ptr through the memory car/cdr
// handshake, streaming each car over elem_valid/elem_ready and reporting the
// element count with an overflow flag when MAX_STEPS is reached.
// Optional: define LIST_WALKER_TIMEOUT_EN to bound each memory wait by
// TIMEOUT_CYCLES (walker_timeout); otherwise waits are unbounded, timeout=0.
module list_walker
  import list_walker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = LW_DATA_WIDTH,
  parameter int unsigned NIL_VALUE      = LW_NIL,
  parameter int unsigned MAX_STEPS      = LW_MAX_STEPS,
  parameter int unsigned COUNT_WIDTH    = LW_COUNT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = LW_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  head_ptr,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   elem_valid,
  input  logic                   elem_ready,
  output logic [DATA_WIDTH-1:0]  elem_data,
  output logic                   mem_car,
  output logic                   mem_cdr,
  output logic                   mem_cons,
  output logic [DATA_WIDTH-1:0]  mem_data_in,
  input  logic [DATA_WIDTH-1:0]  mem_data_out,
  input  logic                   mem_ready
);

  localparam logic [DATA_WIDTH-1:0]  NIL     = DATA_WIDTH'(NIL_VALUE);
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_STEPS);

  logic [LW_STATE_W-1:0]  state_q, state_d;
  logic [DATA_WIDTH-1:0]  ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]  elem_q, elem_d;
  logic [DATA_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   timeout_q, timeout_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   valid_q, valid_d;
  lw_mem_req_t            req_q, req_d;
  logic                   wait_expired_c;

`ifdef LIST_WALKER_TIMEOUT_EN
  logic tmo_load_c;
  logic tmo_en_c;
  logic tmo_expired;

  // Every wait is entered from a request state, so reload there.
  assign tmo_load_c = lw_is_req(state_q);
  assign tmo_en_c   = lw_is_wait(state_q) && !mem_ready;

  walker_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmo_load_c),
    .en_i      (tmo_en_c),
    .expired_o (tmo_expired)
  );

  assign wait_expired_c = tmo_expired;
`else
  // Waits are unbounded; TIMEOUT_CYCLES only matters with the wait counter built in.
  localparam bit TIMEOUT_BUILT = 1'b0;
  assign wait_expired_c = TIMEOUT_BUILT && (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and walk bookkeeping.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    elem_d     = elem_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;

    case (state_q)
      LW_IDLE: begin
        if (start) begin
          count_d    = '0;
          overflow_d = 1'b0;
          timeout_d  = 1'b0;
          ptr_d      = head_ptr;
          state_d    = (head_ptr == NIL) ? LW_DONE : LW_REQ_CAR;
        end
      end
      LW_REQ_CAR: state_d = LW_WAIT_CAR;
      LW_WAIT_CAR: begin
        if (mem_ready) begin
          elem_d  = mem_data_out;
          state_d = LW_EMIT;
        end else if (wait_expired_c) begin
          timeout_d = 1'b1;
          state_d   = LW_DONE;
        end
      end
      LW_EMIT: begin
        if (elem_ready) begin
          count_d = count_q + COUNT_WIDTH'(1);
          state_d = LW_REQ_CDR;
        end
      end
      LW_REQ_CDR: state_d = LW_WAIT_CDR;
      LW_WAIT_CDR: begin
        if (mem_ready) begin
          ptr_d = mem_data_out;
          if (mem_data_out == NIL) begin
            state_d = LW_DONE;
          end else if (count_q == MAX_CNT) begin
            overflow_d = 1'b1;
            state_d    = LW_DONE;
          end else begin
            state_d = LW_REQ_CAR;
          end
        end else if (wait_expired_c) begin
          timeout_d = 1'b1;
          state_d   = LW_DONE;
        end
      end
      LW_DONE: state_d = LW_IDLE;
      default: state_d = LW_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a register.
  always_comb begin
    busy_d    = (state_d != LW_IDLE);
    done_d    = (state_d == LW_DONE);
    valid_d   = (state_d == LW_EMIT);
    req_d.car = (state_d == LW_REQ_CAR);
    req_d.cdr = (state_d == LW_REQ_CDR);
    addr_d    = lw_is_req(state_d) ? ptr_d : '0;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LW_IDLE;
      ptr_q      <= NIL;
      elem_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      req_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      elem_q     <= elem_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;
  assign count       = count_q;
  assign elem_valid  = valid_q;
  assign elem_data   = elem_q;
  assign mem_car     = req_q.car;
  assign mem_cdr     = req_q.cdr;
  assign mem_cons    = 1'b0;
  assign mem_data_in = addr_q;

endmodule

// File: tb/tb_list_walker.sv
// tb_list_walker: scoreboard bench for list_walker with a behavioural
// one-cycle memory; a second instance with MAX_STEPS=4 covers overflow.
module tb_list_walker;

  localparam int unsigned DW = 24;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Main instance signals.
  logic          start = 1'b0;
  logic [DW-1:0] head_ptr = '0;
  logic          busy, done, overflow, timeout;
  logic [CW-1:0] count;
  logic          elem_valid;
  logic          elem_ready = 1'b1;
  logic [DW-1:0] elem_data;
  logic          mem_car, mem_cdr, mem_cons;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic          mem_ready = 1'b0;

  // Overflow instance signals.
  logic          o_start = 1'b0;
  logic [DW-1:0] o_head_ptr = '0;
  logic          o_busy, o_done, o_overflow, o_timeout;
  logic [CW-1:0] o_count;
  logic          o_elem_valid;
  logic          o_elem_ready = 1'b1;
  logic [DW-1:0] o_elem_data;
  logic          o_mem_car, o_mem_cdr, o_mem_cons;
  logic [DW-1:0] o_mem_data_in;
  logic [DW-1:0] o_mem_data_out = '0;
  logic          o_mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] car_m [logic [DW-1:0]];
  logic [DW-1:0] cdr_m [logic [DW-1:0]];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  bit            mem_en = 1'b1;
  int            n_car = 0;
  int            n_cdr = 0;
  int            proto_err = 0;
  logic          prev_req = 1'b0;

  always #5 clk = ~clk;

  list_walker #(
    .DATA_WIDTH(DW), .NIL_VALUE(0), .MAX_STEPS(255), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .head_ptr(head_ptr),
    .busy(busy), .done(done), .overflow(overflow), .timeout(timeout), .count(count),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
    .mem_car(mem_car), .mem_cdr(mem_cdr), .mem_cons(mem_cons), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  list_walker #(
    .DATA_WIDTH(DW), .NIL_VALUE(0), .MAX_STEPS(4), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(8)
  ) dut_ovf (
    .clk(clk), .rst(rst), .start(o_start), .head_ptr(o_head_ptr),
    .busy(o_busy), .done(o_done), .overflow(o_overflow), .timeout(o_timeout), .count(o_count),
    .elem_valid(o_elem_valid), .elem_ready(o_elem_ready), .elem_data(o_elem_data),
    .mem_car(o_mem_car), .mem_cdr(o_mem_cdr), .mem_cons(o_mem_cons), .mem_data_in(o_mem_data_in),
    .mem_data_out(o_mem_data_out), .mem_ready(o_mem_ready)
  );

  function automatic logic [DW-1:0] mem_read(input logic car, input logic [DW-1:0] a);
    if (car) return car_m.exists(a) ? car_m[a] : '0;
    return cdr_m.exists(a) ? cdr_m[a] : '0;
  endfunction

  // Memory: answers a request pulse in the following cycle.
  always @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_data_out <= '0;
    end else begin
      mem_ready <= mem_en && (mem_car || mem_cdr);
      mem_data_out <= (mem_car || mem_cdr) ? mem_read(mem_car, mem_data_in) : '0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      o_mem_ready <= 1'b0;
      o_mem_data_out <= '0;
    end else begin
      o_mem_ready <= o_mem_car || o_mem_cdr;
      o_mem_data_out <= (o_mem_car || o_mem_cdr) ? mem_read(o_mem_car, o_mem_data_in) : '0;
    end
  end

  // Request protocol monitor for the main instance.
  always @(posedge clk) begin
    if (rst) begin
      prev_req <= 1'b0;
    end else begin
      if (mem_car && mem_cdr) proto_err <= proto_err + 1;
      if ((mem_car || mem_cdr) && prev_req) proto_err <= proto_err + 1;
      if (mem_car) n_car <= n_car + 1;
      if (mem_cdr) n_cdr <= n_cdr + 1;
      prev_req <= mem_car || mem_cdr;
    end
  end

  task automatic load_three_cell();
    car_m[24'h002405] = 24'h000011; cdr_m[24'h002405] = 24'h002410;
    car_m[24'h002410] = 24'h000022; cdr_m[24'h002410] = 24'h002420;
    car_m[24'h002420] = 24'h000033; cdr_m[24'h002420] = 24'h000000;
  endtask

  // Starts a walk on the main instance; k = cycles from start edge to done (-1 on budget expiry).
  task automatic run_walk(input logic [DW-1:0] head, input int budget, output int k);
    got_q.delete();
    @(negedge clk); start = 1'b1; head_ptr = head;
    @(negedge clk); start = 1'b0; k = 1;
    while (!done && k < budget) begin
      if (elem_valid && elem_ready) got_q.push_back(elem_data);
      @(negedge clk); k++;
    end
    if (!done) k = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, overflow, timeout, elem_valid, mem_car, mem_cdr, mem_cons} !== 8'h00) begin
      errors++; $display("FAIL reset_flags got %b want 00000000",
                         {busy, done, overflow, timeout, elem_valid, mem_car, mem_cdr, mem_cons});
    end
    checks++;
    if ({count, elem_data, mem_data_in} !== '0) begin
      errors++; $display("FAIL reset_data got count=%h elem=%h addr=%h want 0", count, elem_data, mem_data_in);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_three_cell();
    int k;
    load_three_cell();
    exp_q.push_back(24'h000011); exp_q.push_back(24'h000022); exp_q.push_back(24'h000033);
    run_walk(24'h002405, 100, k);
    checks++;
    if (k !== 16) begin errors++; $display("FAIL three_latency got %0d want 16", k); end
    checks++;
    if (count !== 8'd3 || overflow !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL three_status got count=%0d ovf=%b tmo=%b busy=%b want 3 0 0 1",
                         count, overflow, timeout, busy);
    end
    checks++;
    if (got_q.size() !== 3) begin errors++; $display("FAIL three_nelem got %0d want 3", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [DW-1:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL three_elem got %h want %h", g, e); end
    end
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 8'd3) begin
      errors++; $display("FAIL three_after got done=%b busy=%b count=%0d want 0 0 3", done, busy, count);
    end
    checks++;
    if (proto_err !== 0 || mem_cons !== 1'b0) begin
      errors++; $display("FAIL three_protocol got err=%0d cons=%b want 0 0", proto_err, mem_cons);
    end
  endtask

  task automatic test_nil_head();
    int k, c0, d0;
    c0 = n_car; d0 = n_cdr;
    run_walk(24'h000000, 20, k);
    checks++;
    if (k !== 1) begin errors++; $display("FAIL nil_latency got %0d want 1", k); end
    checks++;
    if (count !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL nil_status got count=%0d ovf=%b want 0 0", count, overflow);
    end
    @(negedge clk);
    checks++;
    if (n_car !== c0 || n_cdr !== d0) begin
      errors++; $display("FAIL nil_noreq got car=%0d cdr=%0d want %0d %0d", n_car, n_cdr, c0, d0);
    end
  endtask

  task automatic test_backpressure();
    int guard, c0, d0;
    logic [DW-1:0] held;
    load_three_cell();
    exp_q.push_back(24'h000011); exp_q.push_back(24'h000022); exp_q.push_back(24'h000033);
    elem_ready = 1'b0;
    @(negedge clk); start = 1'b1; head_ptr = 24'h002405;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!elem_valid && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (elem_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", elem_valid); end
    held = elem_data;
    begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (held !== e) begin errors++; $display("FAIL bp_first got %h want %h", held, e); end
    end
    c0 = n_car; d0 = n_cdr;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (elem_valid !== 1'b1 || elem_data !== held || mem_car !== 1'b0 || mem_cdr !== 1'b0) begin
        errors++; $display("FAIL bp_stall%0d got v=%b d=%h car=%b cdr=%b want 1 %h 0 0",
                           i, elem_valid, elem_data, mem_car, mem_cdr, held);
      end
    end
    checks++;
    if (n_car !== c0 || n_cdr !== d0) begin
      errors++; $display("FAIL bp_noreq got car=%0d cdr=%0d want %0d %0d", n_car, n_cdr, c0, d0);
    end
    elem_ready = 1'b1;
    @(negedge clk);
    got_q.delete();
    guard = 0;
    while (!done && guard < 40) begin
      if (elem_valid) got_q.push_back(elem_data);
      @(negedge clk); guard++;
    end
    checks++;
    if (done !== 1'b1 || count !== 8'd3) begin
      errors++; $display("FAIL bp_done got done=%b count=%0d want 1 3", done, count);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL bp_nelem got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [DW-1:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL bp_elem got %h want %h", g, e); end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int k;
    car_m[24'h000100] = 24'h0000A1; cdr_m[24'h000100] = 24'h000200;
    car_m[24'h000200] = 24'h0000A2; cdr_m[24'h000200] = 24'h000100;
    exp_q.push_back(24'h0000A1); exp_q.push_back(24'h0000A2);
    exp_q.push_back(24'h0000A1); exp_q.push_back(24'h0000A2);
    got_q.delete();
    @(negedge clk); o_start = 1'b1; o_head_ptr = 24'h000100;
    @(negedge clk); o_start = 1'b0; k = 1;
    while (!o_done && k < 100) begin
      if (o_elem_valid) got_q.push_back(o_elem_data);
      @(negedge clk); k++;
    end
    checks++;
    if (o_done !== 1'b1 || k !== 21) begin
      errors++; $display("FAIL ovf_latency got done=%b k=%0d want 1 21", o_done, k);
    end
    checks++;
    if (o_overflow !== 1'b1 || o_count !== 8'd4 || o_timeout !== 1'b0) begin
      errors++; $display("FAIL ovf_status got ovf=%b count=%0d tmo=%b want 1 4 0", o_overflow, o_count, o_timeout);
    end
    checks++;
    if (got_q.size() !== 4) begin errors++; $display("FAIL ovf_nelem got %0d want 4", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [DW-1:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL ovf_elem got %h want %h", g, e); end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_walk();
    int k, guard;
    load_three_cell();
    @(negedge clk); start = 1'b1; head_ptr = 24'h002405;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!mem_cdr && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_cdr !== 1'b0) begin
      errors++; $display("FAIL rstmid_reach got busy=%b cdr=%b want 1 0", busy, mem_cdr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, overflow, timeout, elem_valid, mem_car, mem_cdr, count, elem_data, mem_data_in} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got busy=%b done=%b count=%0d elem=%h addr=%h want all 0",
                         busy, done, count, elem_data, mem_data_in);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_nodone got done=%b busy=%b want 0 0", done, busy);
    end
    exp_q.push_back(24'h000011); exp_q.push_back(24'h000022); exp_q.push_back(24'h000033);
    run_walk(24'h002405, 100, k);
    checks++;
    if (k !== 16 || count !== 8'd3) begin
      errors++; $display("FAIL rstmid_rewalk got k=%0d count=%0d want 16 3", k, count);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [DW-1:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rstmid_elem got %h want %h", g, e); end
    end
    checks++;
    if (exp_q.size() !== 0 || got_q.size() !== 0) begin
      errors++; $display("FAIL rstmid_nelem got left exp=%0d got=%0d want 0 0", exp_q.size(), got_q.size());
    end
    exp_q.delete();
    @(negedge clk);
  endtask

`ifdef LIST_WALKER_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    load_three_cell();
    mem_en = 1'b0;
    run_walk(24'h002405, 60, k);
    checks++;
    if (k !== 10) begin errors++; $display("FAIL tmo_latency got %0d want 10", k); end
    checks++;
    if (timeout !== 1'b1 || count !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL tmo_status got tmo=%b count=%0d ovf=%b want 1 0 0", timeout, count, overflow);
    end
    mem_en = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_three_cell();
    test_nil_head();
    test_backpressure();
    test_overflow();
    test_reset_mid_walk();
`ifdef LIST_WALKER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/list_walker.md
Name: list_walker

Overview:
- Parametrised successor to the hard-coded car-request sequencer in the top level.
- Walks a cons-cell list through the memory_unit car/cdr handshake, starting from a head pointer.
- Streams each car element out over a valid/ready port and reports the element count, plus an overflow flag when the list exceeds a step bound.
- Sits between the top-level control and memory_unit; it is the sole driver of the memory request lines while busy.

Parameters:
DATA_WIDTH, 24, width of memory words, pointers and elements (matches memory_data_width)
NIL_VALUE, 0, pointer value terminating a list
MAX_STEPS, 255, maximum elements emitted before forced stop with overflow
COUNT_WIDTH, 8, width of count; must hold MAX_STEPS
TIMEOUT_CYCLES, 64, memory wait limit (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin walk; sampled only in IDLE
head_ptr  in  DATA_WIDTH  list head, captured with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at walk end
overflow  out  1  valid with done; step bound hit
timeout  out  1  valid with done; memory wait expired (0 without feature)
count  out  COUNT_WIDTH  elements emitted; held until next start
elem_valid  out  1  element available
elem_ready  in  1  consumer accepts element
elem_data  out  DATA_WIDTH  car of current cell
mem_car  out  1  car request pulse
mem_cdr  out  1  cdr request pulse
mem_cons  out  1  tied 0
mem_data_in  out  DATA_WIDTH  cell pointer for request
mem_data_out  in  DATA_WIDTH  memory response
mem_ready  in  1  response valid

Behaviour:
- Reset state: all outputs 0, state IDLE, internal pointer NIL_VALUE. A reset mid-walk aborts immediately; no done pulse is generated.
- All outputs are registered.
- States: IDLE, REQ_CAR, WAIT_CAR, EMIT, REQ_CDR, WAIT_CDR, DONE.
- IDLE:
  - start=1 with head_ptr!=NIL: capture ptr, clear count/overflow/timeout, go to REQ_CAR.
  - start=1 with head_ptr==NIL: go to DONE, count=0.
- REQ_CAR (exactly 1 cycle): mem_car=1, mem_data_in=ptr; go to WAIT_CAR.
- WAIT_CAR:
  - mem_car=0 and mem_data_in=0.
  - mem_ready is sampled from the first WAIT cycle on; when it is 1, capture mem_data_out into elem_data and go to EMIT.
- EMIT:
  - elem_valid=1 and elem_data stable until elem_ready=1 on a clock edge.
  - On that edge: count+1, elem_valid drops next cycle, go to REQ_CDR.
- REQ_CDR (1 cycle): mem_cdr=1, mem_data_in=ptr; go to WAIT_CDR.
- WAIT_CDR, on mem_ready:
  - Load ptr=mem_data_out.
  - If mem_data_out==NIL: go to DONE.
  - Else if count==MAX_STEPS: overflow=1, go to DONE.
  - Else: go to REQ_CAR.
- DONE: done=1 for one cycle, then IDLE. count, overflow and timeout hold until the next accepted start.
- start while busy is ignored; it is not queued.
- mem_car and mem_cdr are never high together and never high for two consecutive cycles.
- Latency, with mem_ready high in the first WAIT cycle and elem_ready held 1:
  - start sampled at edge T; mem_car high in cycle T+1.
  - Each cell takes 5 cycles.
  - done asserts the cycle after the final WAIT_CDR.
- count saturates by construction, because MAX_STEPS stops the walk.

Optional Feature:
- Macro LIST_WALKER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT_CAR or WAIT_CDR.
  - If mem_ready has not arrived after TIMEOUT_CYCLES cycles, set timeout=1 and go to DONE. count holds the elements emitted so far.
- Undefined: no counter logic; timeout is tied to 0 and waits are unbounded.

Decomposition:
- Shared header list_walker.vh holds:
  - state encodings (3-bit localparams)
  - LW_NIL default
  - default widths, derived from memory_data_width in memory_unit.vh
- One natural sub-module, walker_timeout: a loadable down-counter with an expired flag, instantiated only under LIST_WALKER_TIMEOUT_EN.

Test Plan:
- Three-cell list 0x002405 -> 0x002410 -> 0x002420 -> NIL, cars 0x11/0x22/0x33, memory answers in 1 cycle, elem_ready=1 -> elements 0x11, 0x22, 0x33 in order; done with count=3, overflow=0; start-to-done is 16 cycles.
- start with head_ptr=0 -> done pulses the cycle after start, count=0, no mem_car or mem_cdr issued.
- Back-pressure: elem_ready low for 4 cycles during EMIT -> elem_valid and elem_data stay stable for those 4 cycles; no mem request is issued until acceptance.
- Circular list with MAX_STEPS=4 -> exactly 4 elements emitted, done with overflow=1, count=4.
- rst pulsed during WAIT_CDR -> all outputs 0 next cycle; a subsequent start completes a normal walk.
- With LIST_WALKER_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never asserted -> done with timeout=1 and count=0 after 8 wait cycles.
